cfg_loader: RTL and testbench

CFG_LOADER -- requirements
Module: cfg_loader

---
 rtl/cfg_pkg.sv | 21 ++
 rtl/cfg_shift_reg.sv | 41 ++++
 rtl/cfg_loader.sv | 136 +++++++++++++
 tb/tb_cfg_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration-chain loader: frame geometry,
// loader state encoding and the frame parity check.
package cfg_pkg;

    localparam int CFG_WORD_W  = 18;
    localparam int CFG_FRAME_W = CFG_WORD_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } cfg_state_t;

    // A frame is good when the data-bit parity and the trailing parity bit XOR to zero.
    function automatic logic frame_par_ok(input logic run_par, input logic par_bit);
        return ((run_par ^ par_bit) == 1'b0);
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-in/parallel-out word register with running parity for one frame.
// The first data bit lands in the MSB; the trailing parity bit never enters the word.
module cfg_shift_reg
    import cfg_pkg::*;
#(
    parameter int WORD_W = CFG_WORD_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              last_en,
    input  logic              bit_in,
    output logic [WORD_W-1:0] word,
    output logic              parity
);

    logic [WORD_W-1:0] word_r;
    logic              par_r;

    // Shift data bits in at the LSB; the parity bit only closes the frame and re-arms parity.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_r <= {WORD_W{1'b0}};
            par_r  <= 1'b0;
        end else if (shift_en && last_en) begin
            word_r <= word_r;
            par_r  <= 1'b0;
        end else if (shift_en) begin
            word_r <= {word_r[WORD_W-2:0], bit_in};
            par_r  <= par_r ^ bit_in;
        end else begin
            word_r <= word_r;
            par_r  <= par_r;
        end
    end

    assign word   = word_r;
    assign parity = par_r;

endmodule

// File: rtl/cfg_loader.sv
// Loads a serial parity-protected bitstream into a chain of switch blocks,
// one WORD_W word per block, strobing each block once in order.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    parameter int WORD_W     = CFG_WORD_W
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    output logic                  bit_ready,
    output logic [NUM_BLOCKS-1:0] wr_en,
    output logic [WORD_W-1:0]     bits,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = (WORD_W + 1 > 1) ? $clog2(WORD_W + 1) : 1;
    localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLOCKS - 1);

    cfg_state_t             state_r, state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [BLK_W-1:0]       blk_r;
    logic [NUM_BLOCKS-1:0]  wr_en_r;
    logic [WORD_W-1:0]      bits_r;
    logic                   bit_ready_r, busy_r, done_r, err_r;
    logic                   start_s, accept_s, last_s, par_s;
    logic [WORD_W-1:0]      word_s;

    cfg_shift_reg #(.WORD_W(WORD_W)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_s),
        .shift_en (accept_s),
        .last_en  (last_s),
        .bit_in   (bit_data),
        .word     (word_s),
        .parity   (par_s)
    );

    // Next-state logic; bit_ready is high exactly in SHIFT so acceptance is SHIFT && bit_valid.
    always_comb begin
        state_s  = state_r;
        start_s  = 1'b0;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    start_s = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SHIFT: begin
                accept_s = bit_valid;
                if (bit_valid && (cnt_r == CNT_LAST)) begin
                    last_s = 1'b1;
                    if (frame_par_ok(par_s, bit_data)) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_ERROR;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_WRITE: begin
                if (blk_r == BLK_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, counters and outputs, all registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            blk_r       <= {BLK_W{1'b0}};
            wr_en_r     <= {NUM_BLOCKS{1'b0}};
            bits_r      <= {WORD_W{1'b0}};
            bit_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_ready_r <= (state_s == ST_SHIFT);
            busy_r      <= (state_s == ST_SHIFT) || (state_s == ST_WRITE);
            done_r      <= (state_s == ST_DONE);
            err_r       <= (state_s == ST_ERROR);
            if (start_s) begin
                cnt_r <= {CNT_W{1'b0}};
                blk_r <= {BLK_W{1'b0}};
            end else if (accept_s) begin
                cnt_r <= last_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
                blk_r <= blk_r;
            end else if ((state_r == ST_WRITE) && (blk_r != BLK_LAST)) begin
                cnt_r <= cnt_r;
                blk_r <= blk_r + BLK_W'(1);
            end else begin
                cnt_r <= cnt_r;
                blk_r <= blk_r;
            end
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                wr_en_r[i] <= (state_s == ST_WRITE) && (blk_r == BLK_W'(i));
            end
            // The word is complete before its parity bit arrives, so it can be latched on that edge.
            if ((state_r == ST_SHIFT) && (state_s == ST_WRITE)) begin
                bits_r <= word_s;
            end else begin
                bits_r <= bits_r;
            end
        end
    end

    assign bit_ready = bit_ready_r;
    assign wr_en     = wr_en_r;
    assign bits      = bits_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: frame-level behavioural model checked every cycle,
// directed scenarios pinned by literal expectations, then randomized loads.
module tb_cfg_loader;

    localparam int NB = 4;
    localparam int WW = 18;
    localparam int P_IDLE = 0, P_LOAD = 1, P_WRITE = 2, P_DONE = 3, P_ERR = 4;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, bit_valid = 1'b0, bit_data = 1'b0;
    logic bit_ready, busy, done, err;
    logic [NB-1:0] wr_en;
    logic [WW-1:0] bits;

    cfg_loader #(.NUM_BLOCKS(NB), .WORD_W(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_data(bit_data),
        .bit_ready(bit_ready), .wr_en(wr_en), .bits(bits), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit stim_q[$];
    int vmode = 0;
    bit tog = 1'b0;
    bit chk_on = 1'b0;
    int ph = P_IDLE, m_blk = 0, acc_cnt = 0;
    bit fb[$];
    logic [WW-1:0] m_bits = '0;
    logic [31:0] act_wr[$];
    logic [WW-1:0] basic_w [4] = '{18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    function automatic logic [31:0] wr_rec(input int blk, input logic [WW-1:0] w);
        logic [NB-1:0] oh;
        oh = '0;
        oh[blk] = 1'b1;
        return {10'd0, oh, w};
    endfunction

    task automatic push_frame(input logic [WW-1:0] w, input bit flip);
        for (int i = WW - 1; i >= 0; i--) stim_q.push_back(w[i]);
        stim_q.push_back((^w) ^ flip);
    endtask

    // Frame-level reference: collect accepted bits, judge each whole frame, step blocks.
    task automatic model_step();
        logic [WW-1:0] w;
        bit p;
        if (rst) begin
            ph = P_IDLE; m_blk = 0; fb.delete(); m_bits = '0;
        end else begin
            case (ph)
                P_IDLE, P_DONE, P_ERR: if (start) begin ph = P_LOAD; m_blk = 0; fb.delete(); end
                P_LOAD: if (bit_valid) begin
                    fb.push_back(bit_data);
                    acc_cnt++;
                    if (stim_q.size() > 0) void'(stim_q.pop_front());
                    if (fb.size() == WW + 1) begin
                        w = '0; p = 1'b0;
                        for (int i = 0; i < WW; i++) w[WW-1-i] = fb[i];
                        for (int i = 0; i <= WW; i++) p ^= fb[i];
                        fb.delete();
                        if (p == 1'b0) begin m_bits = w; ph = P_WRITE; end
                        else ph = P_ERR;
                    end
                end
                P_WRITE: if (m_blk == NB - 1) ph = P_DONE; else begin m_blk++; ph = P_LOAD; end
                default: ph = P_IDLE;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Bit source: presents the head of the stimulus queue with the selected valid pattern.
    initial forever begin
        bit v;
        @(negedge clk);
        tog = ~tog;
        case (vmode)
            0: v = 1'b1;
            1: v = tog;
            default: v = ($urandom_range(3, 0) != 0);
        endcase
        if (stim_q.size() > 0) begin bit_valid = v; bit_data = stim_q[0]; end
        else begin bit_valid = 1'b0; bit_data = 1'b0; end
    end

    // Per-cycle compare against the model, plus a log of every write strobe seen.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("bit_ready", bit_ready, ph == P_LOAD);
            chk("busy", busy, (ph == P_LOAD) || (ph == P_WRITE));
            chk("done", done, ph == P_DONE);
            chk("err", err, ph == P_ERR);
            chk("wr_en", wr_en, (ph == P_WRITE) ? (64'd1 << m_blk) : 64'd0);
            chk("bits", bits, m_bits);
            if (wr_en !== '0) act_wr.push_back({10'd0, wr_en, bits});
        end
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!((done === 1'b1) || (err === 1'b1)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("wait_end");
    endtask

    task automatic wait_acc(input int target);
        int k;
        k = 0;
        while (acc_cnt < target && k < 1000) begin @(negedge clk); k++; end
        if (k >= 1000) fail_now("wait_acc");
    endtask

    task automatic chk_basic_writes(input string name);
        chk({name, "_nwr"}, act_wr.size(), NB);
        for (int k = 0; k < NB; k++)
            if (k < act_wr.size()) chk({name, "_wr"}, act_wr[k], wr_rec(k, basic_w[k]));
    endtask

    initial begin
        int n, a0, nexp;
        logic [WW-1:0] rw [NB];
        bit any_flip;
        bit flip;

        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_bits", bits, 0);
        chk("rst_ready", bit_ready, 0);
        chk("rst_flags", {busy, done, err}, 0);
        rst = 1'b0;

        // Basic load with continuous valid.
        vmode = 0; act_wr.delete();
        for (int k = 0; k < NB; k++) push_frame(basic_w[k], 1'b0);
        do_start();
        wait_end(n);
        chk("basic_cycles", n, NB * (WW + 2));
        chk("basic_done", done, 1);
        chk("basic_err", err, 0);
        chk_basic_writes("basic");

        // Restart from DONE rewrites block 0 first.
        act_wr.delete();
        for (int k = 0; k < NB; k++) begin rw[k] = WW'($urandom); push_frame(rw[k], 1'b0); end
        do_start();
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        wait_end(n);
        chk("restart_nwr", act_wr.size(), NB);
        if (act_wr.size() > 0) chk("restart_first", act_wr[0], wr_rec(0, rw[0]));

        // Stalls: valid toggling every cycle.
        vmode = 1; act_wr.delete();
        for (int k = 0; k < NB; k++) push_frame(basic_w[k], 1'b0);
        do_start();
        wait_end(n);
        chk("stall_cycles", (n >= 2 * NB * (WW + 1) - 4) && (n <= 2 * NB * (WW + 2) + 8), 1);
        chk_basic_writes("stall");

        // Parity error on the second frame.
        vmode = 0; act_wr.delete();
        push_frame(18'h3FFFF, 1'b0);
        push_frame(18'h00001, 1'b1);
        push_frame(18'h2AAAA, 1'b0);
        push_frame(18'h15555, 1'b0);
        do_start();
        wait_end(n);
        chk("perr_err", err, 1);
        chk("perr_done", done, 0);
        chk("perr_ready", bit_ready, 0);
        chk("perr_nwr", act_wr.size(), 1);
        if (act_wr.size() > 0) chk("perr_wr", act_wr[0], wr_rec(0, 18'h3FFFF));
        stim_q.delete();

        // Start while busy is ignored.
        act_wr.delete();
        for (int k = 0; k < NB; k++) push_frame(basic_w[k], 1'b0);
        a0 = acc_cnt;
        do_start();
        wait_acc(a0 + 5);
        do_start();
        wait_end(n);
        chk("busy_start_done", done, 1);
        chk_basic_writes("busy_start");

        // Reset after 10 bits of the second frame, with start in the same cycle.
        act_wr.delete();
        for (int k = 0; k < NB; k++) push_frame(basic_w[k], 1'b0);
        a0 = acc_cnt;
        do_start();
        wait_acc(a0 + WW + 1 + 10);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        stim_q.delete();
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_bits", bits, 0);
        chk("mid_rst_flags", {bit_ready, busy, done, err}, 0);
        repeat (30) @(negedge clk);
        chk("mid_rst_nwr", act_wr.size(), 1);
        if (act_wr.size() > 0) chk("mid_rst_wr", act_wr[0], wr_rec(0, basic_w[0]));

        // Randomized loads with random valid gaps and occasional bad parity.
        vmode = 2;
        for (int it = 0; it < 16; it++) begin
            act_wr.delete(); stim_q.delete();
            nexp = NB; any_flip = 1'b0;
            for (int k = 0; k < NB; k++) begin
                rw[k] = WW'($urandom);
                flip = ($urandom_range(7, 0) == 0);
                if (flip && !any_flip) begin nexp = k; any_flip = 1'b1; end
                push_frame(rw[k], flip);
            end
            do_start();
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(8, 2)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_end(n);
            chk("rand_err", err, any_flip);
            chk("rand_nwr", act_wr.size(), nexp);
            for (int k = 0; k < nexp; k++)
                if (k < act_wr.size()) chk("rand_wr", act_wr[k], wr_rec(k, rw[k]));
            stim_q.delete();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
